// File: rtl/edge_preserve_filter_mc.sv
// edge_preserve_filter_mc: 3-stage valid/ready 3x3 multi-kernel smoothing filter over packed channels.
// Define EDGE_FILTER_ROUND_EN for round-half-up instead of truncation.
module edge_preserve_filter_mc #(
  parameter int DATA_W = 8,
  parameter int CHANNELS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in1,
  input  logic [CHANNELS*DATA_W-1:0] in2,
  input  logic [CHANNELS*DATA_W-1:0] in3,
  input  logic [CHANNELS*DATA_W-1:0] in4,
  input  logic [CHANNELS*DATA_W-1:0] in5,
  input  logic [CHANNELS*DATA_W-1:0] in6,
  input  logic [CHANNELS*DATA_W-1:0] in7,
  input  logic [CHANNELS*DATA_W-1:0] in8,
  input  logic [CHANNELS*DATA_W-1:0] in9,
  input  logic [2:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS*DATA_W-1:0] result,
  output logic [2:0]                 out_mode
);
  localparam int W = CHANNELS*DATA_W;
  localparam int SW = DATA_W+4;
`ifdef EDGE_FILTER_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(8);
`else
  localparam logic [SW-1:0] RND = '0;
`endif
  logic en, s1_valid, s2_valid;
  logic [2:0] s1_mode, s2_mode;
  logic [8:0][W-1:0] s1_win;
  logic [CHANNELS-1:0][SW-1:0] top_d, mid_d, bot_d, top_q, mid_q, bot_q;
  logic [CHANNELS-1:0][DATA_W-1:0] res_d, res_q;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  // top/bottom rows share weights; the centre row carries the bypass x16 tap
  function automatic logic [SW-1:0] outer_row(input logic [DATA_W-1:0] a, b, c, input logic [2:0] m);
    logic [SW-1:0] x, y, z;
    x = SW'(a);
    y = SW'(b);
    z = SW'(c);
    return m == 3'd0 ? x + (y << 1) + z :
           m == 3'd1 ? (x << 1) + y + (z << 1) :
           m == 3'd2 ? x + y + z :
           m == 3'd3 ? x + (y << 1) + y + z : '0;
  endfunction
  function automatic logic [SW-1:0] centre_row(input logic [DATA_W-1:0] a, b, c, input logic [2:0] m);
    logic [SW-1:0] x, y, z;
    x = SW'(a);
    y = SW'(b);
    z = SW'(c);
    return m == 3'd0 ? (x << 1) + (y << 2) + (z << 1) :
           m == 3'd2 ? (x << 1) + x + (y << 2) + (z << 1) + z :
           (m == 3'd1 || m == 3'd3) ? x + (y << 2) + z : y << 4;
  endfunction
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign top_d[c] = outer_row(s1_win[0][c*DATA_W +: DATA_W], s1_win[1][c*DATA_W +: DATA_W],
                                s1_win[2][c*DATA_W +: DATA_W], s1_mode);
    assign mid_d[c] = centre_row(s1_win[3][c*DATA_W +: DATA_W], s1_win[4][c*DATA_W +: DATA_W],
                                 s1_win[5][c*DATA_W +: DATA_W], s1_mode);
    assign bot_d[c] = outer_row(s1_win[6][c*DATA_W +: DATA_W], s1_win[7][c*DATA_W +: DATA_W],
                                s1_win[8][c*DATA_W +: DATA_W], s1_mode);
    assign res_d[c] = DATA_W'((top_q[c] + mid_q[c] + bot_q[c] + RND) >> 4);
    assign result[c*DATA_W +: DATA_W] = res_q[c];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode <= '0;
      s1_win <= '0;
      s2_valid <= 1'b0;
      s2_mode <= '0;
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
      out_valid <= 1'b0;
      out_mode <= '0;
      res_q <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_mode <= mode;
      s1_win <= {in9, in8, in7, in6, in5, in4, in3, in2, in1};
      s2_valid <= s1_valid;
      s2_mode <= s1_mode;
      top_q <= top_d;
      mid_q <= mid_d;
      bot_q <= bot_d;
      out_valid <= s2_valid;
      out_mode <= s2_mode;
      res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_edge_preserve_filter_mc.sv
// tb_edge_preserve_filter_mc: directed + random checks of two filter instances against a kernel-table model.
module tb_edge_preserve_filter_mc;
`ifdef EDGE_FILTER_ROUND_EN
  localparam int RND = 8;
`else
  localparam int RND = 0;
`endif
  logic clk = 0, rst = 1;
  logic in_valid_a = 0, in_valid_b = 0, out_ready_a = 1, out_ready_b = 1;
  logic [2:0] mode = 0;
  logic [29:0] win[9];
  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [7:0] result_a;
  logic [29:0] result_b;
  logic [2:0] out_mode_a, out_mode_b;
  int n_assert = 0, n_fail = 0;
  int na_in = 0, na_out = 0, nb_in = 0, nb_out = 0;
  logic [32:0] qa[$], qb[$];
  int kern[5][9] = '{'{1,2,1,2,4,2,1,2,1}, '{2,1,2,1,4,1,2,1,2}, '{1,1,1,3,4,3,1,1,1},
                     '{1,3,1,1,4,1,1,3,1}, '{0,0,0,0,16,0,0,0,0}};

  always #5 clk = ~clk;

  edge_preserve_filter_mc dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in1(win[0][7:0]), .in2(win[1][7:0]), .in3(win[2][7:0]), .in4(win[3][7:0]), .in5(win[4][7:0]),
    .in6(win[5][7:0]), .in7(win[6][7:0]), .in8(win[7][7:0]), .in9(win[8][7:0]),
    .mode(mode), .out_valid(out_valid_a), .out_ready(out_ready_a), .result(result_a), .out_mode(out_mode_a));

  edge_preserve_filter_mc #(.DATA_W(10), .CHANNELS(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in1(win[0]), .in2(win[1]), .in3(win[2]), .in4(win[3]), .in5(win[4]),
    .in6(win[5]), .in7(win[6]), .in8(win[7]), .in9(win[8]),
    .mode(mode), .out_valid(out_valid_b), .out_ready(out_ready_b), .result(result_b), .out_mode(out_mode_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // weighted sum of each channel lane, codes above 3 use the centre-only kernel
  function automatic logic [29:0] model(input int dw, input int ch, input logic [2:0] m, input logic [29:0] w[9]);
    logic [29:0] r;
    int s, k;
    r = '0;
    k = m > 3 ? 4 : int'(m);
    for (int c = 0; c < ch; c++) begin
      s = RND;
      for (int i = 0; i < 9; i++) s += kern[k][i] * int'((w[i] >> (c*dw)) & ((30'd1 << dw) - 1));
      r |= 30'(s >> 4) << (c*dw);
    end
    return r;
  endfunction

  logic stall_a = 0;
  logic [7:0] prev_res_a;
  logic [2:0] prev_mode_a;
  logic [32:0] ea, eb;
  logic [29:0] ma, mb;

  always @(negedge clk) begin
    if (rst) begin
      qa.delete(); qb.delete();
      na_in = na_out; nb_in = nb_out;
      stall_a = 0;
    end else begin
      if (stall_a) begin
        check("stall_valid", out_valid_a, 1);
        check("stall_result", result_a, prev_res_a);
        check("stall_mode", out_mode_a, prev_mode_a);
      end
      if (out_valid_a && out_ready_a) begin
        if (qa.size() == 0) check("a_extra_output", out_valid_a, 0);
        else begin
          ea = qa.pop_front();
          check("a_result", result_a, ea[7:0]);
          check("a_mode", out_mode_a, ea[32:30]);
          na_out++;
        end
      end
      if (out_valid_b && out_ready_b) begin
        if (qb.size() == 0) check("b_extra_output", out_valid_b, 0);
        else begin
          eb = qb.pop_front();
          check("b_result", result_b, eb[29:0]);
          check("b_mode", out_mode_b, eb[32:30]);
          nb_out++;
        end
      end
      if (in_valid_a && in_ready_a) begin
        ma = model(8, 1, mode, win);
        qa.push_back({mode, ma});
        na_in++;
      end
      if (in_valid_b && in_ready_b) begin
        mb = model(10, 3, mode, win);
        qb.push_back({mode, mb});
        nb_in++;
      end
      stall_a = out_valid_a && !out_ready_a;
      prev_res_a = result_a;
      prev_mode_a = out_mode_a;
    end
  end

  task automatic send(input logic b, input logic [2:0] m);
    int t;
    mode = m;
    if (b) in_valid_b = 1; else in_valid_a = 1;
    t = 0;
    @(negedge clk);
    while (!(b ? in_ready_b : in_ready_a) && t < 50) begin @(negedge clk); t++; end
    check("accept", b ? in_ready_b : in_ready_a, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_one(input logic b, input logic [2:0] m, input logic [29:0] exp);
    send(b, m);
    in_valid_a = 0; in_valid_b = 0;
    check("lat_edge0", b ? out_valid_b : out_valid_a, 0);
    @(posedge clk); #1;
    check("lat_edge1", b ? out_valid_b : out_valid_a, 0);
    @(posedge clk); #1;
    check("lat_edge2_valid", b ? out_valid_b : out_valid_a, 1);
    check("lat_edge2_result", b ? result_b : 30'(result_a), exp);
    check("lat_edge2_mode", b ? out_mode_b : out_mode_a, m);
    @(posedge clk); #1;
  endtask

  task automatic fill(input logic [29:0] v);
    for (int i = 0; i < 9; i++) win[i] = v;
  endtask

  initial begin
    fill(0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_valid_a", out_valid_a, 0);
    check("rst_result_a", result_a, 0);
    check("rst_mode_a", out_mode_a, 0);
    check("rst_ready_a", in_ready_a, 1);
    check("rst_valid_b", out_valid_b, 0);
    check("rst_result_b", result_b, 0);
    fill(100);
    run_one(0, 3'd1, 100);
    fill(0); win[4] = 255;
    run_one(0, 3'd0, RND ? 64 : 63);
    fill(0); win[3] = 16; win[4] = 16; win[5] = 16;
    run_one(0, 3'd2, 10);
    fill(0); win[1] = 160; win[4] = 160; win[7] = 160;
    run_one(0, 3'd3, 100);
    fill(200); win[4] = 77;
    run_one(0, 3'd4, 77);
    run_one(0, 3'd6, 77);
    for (int k = 0; k < 10; k++) begin
      logic [2:0] m;
      m = 3'($urandom_range(0, 7));
      for (int i = 0; i < 9; i++) win[i] = 30'($urandom_range(0, 255));
      if (k == 6) begin
        mode = m; in_valid_a = 1; out_ready_a = 0;
        repeat (4) begin
          @(posedge clk); #1;
          check("stall_in_ready", in_ready_a, 0);
        end
        out_ready_a = 1;
      end
      send(0, m);
    end
    in_valid_a = 0;
    repeat (6) @(posedge clk);
    #1;
    check("a_drained", qa.size(), 0);
    check("a_count", na_out, na_in);
    fill({10'd512, 10'd0, 10'd1023});
    run_one(1, 3'd1, {10'd512, 10'd0, 10'd1023});
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 9; i++) win[i] = 30'($urandom);
      send(1, 3'($urandom_range(0, 7)));
    end
    in_valid_b = 0;
    repeat (6) @(posedge clk);
    #1;
    check("b_count", nb_out, nb_in);
    fill(30'h155);
    send(1, 3'd0);
    send(1, 3'd2);
    in_valid_b = 0; rst = 1;
    @(posedge clk); #1;
    check("midrst_valid", out_valid_b, 0);
    check("midrst_result", result_b, 0);
    check("midrst_mode", out_mode_b, 0);
    rst = 0;
    check("midrst_ready", in_ready_b, 1);
    repeat (6) begin
      @(posedge clk); #1;
      check("no_stale", out_valid_b, 0);
    end
    check("b_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
